// File: rtl/tff_btn_pulse.sv
// Push-button front end for a T flip-flop: synchronizes and debounces a raw
// button and emits one t pulse per press. Optional auto-repeat: TFF_BTN_AUTO_REPEAT_EN.
module tff_btn_pulse #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       t,
  output logic       pressed,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  state_t     state_r;
  logic       sync0_r;
  logic       sync1_r;
  logic       btn_s;
  logic [7:0] db_cnt_r;
`ifdef TFF_BTN_AUTO_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rep_cnt_r;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'd255) begin
      sat_inc8 = 8'd255;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

  assign btn_s = sync1_r;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
    end else begin
      sync0_r <= btn;
      sync1_r <= sync0_r;
    end
  end

  // Debounce FSM with registered t, pressed and glitch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      db_cnt_r   <= 8'd0;
      t          <= 1'b0;
      pressed    <= 1'b0;
      glitch_cnt <= 8'd0;
`ifdef TFF_BTN_AUTO_REPEAT_EN
      rep_cnt_r  <= 16'd0;
`endif
    end else begin
      t <= 1'b0;
      case (state_r)
        IDLE: begin
          if (btn_s) begin
            state_r  <= PRESS_WAIT;
            db_cnt_r <= 8'd1;
          end else begin
            state_r  <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_r    <= IDLE;
            glitch_cnt <= sat_inc8(glitch_cnt);
          end else if (db_cnt_r == DB_LAST) begin
            state_r    <= PRESSED;
            pressed    <= 1'b1;
            t          <= 1'b1;
`ifdef TFF_BTN_AUTO_REPEAT_EN
            rep_cnt_r  <= 16'd0;
`endif
          end else begin
            db_cnt_r   <= db_cnt_r + 8'd1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_r   <= RELEASE_WAIT;
            db_cnt_r  <= 8'd1;
`ifdef TFF_BTN_AUTO_REPEAT_EN
            rep_cnt_r <= 16'd0;
          end else if (rep_cnt_r == REP_LAST) begin
            t         <= 1'b1;
            rep_cnt_r <= 16'd0;
          end else begin
            rep_cnt_r <= rep_cnt_r + 16'd1;
`else
          end else begin
            state_r   <= PRESSED;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            // Bounce on release: back to PRESSED without a new pulse
            state_r    <= PRESSED;
            glitch_cnt <= sat_inc8(glitch_cnt);
`ifdef TFF_BTN_AUTO_REPEAT_EN
            rep_cnt_r  <= 16'd0;
`endif
          end else if (db_cnt_r == DB_LAST) begin
            state_r    <= IDLE;
            pressed    <= 1'b0;
          end else begin
            db_cnt_r   <= db_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          pressed  <= 1'b0;
          db_cnt_r <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_btn_pulse.sv
// Directed self-checking bench for tff_btn_pulse (defaults DB_CYCLES=4,
// REPEAT_CYCLES=16); expectations follow TFF_BTN_AUTO_REPEAT_EN when defined.
module tb_tff_btn_pulse;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       t;
  logic       pressed;
  logic [7:0] glitch_cnt;
  logic       q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int p_count  = 0;
  int pulse_cyc[$];

`ifdef TFF_BTN_AUTO_REPEAT_EN
  localparam int EXP_CLEAN_PULSES  = 2;
  localparam int EXP_REPEAT_PULSES = 4;
`else
  localparam int EXP_CLEAN_PULSES  = 1;
  localparam int EXP_REPEAT_PULSES = 1;
`endif

  tff_btn_pulse dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .t          (t),
    .pressed    (pressed),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream T flip-flop driven by t
  always @(posedge clk) begin
    if (rst) q <= 1'b0;
    else if (t) q <= ~q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (t === 1'b1) begin
      p_count++;
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    btn = 1'b0;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    p_count = 0;
    pulse_cyc.delete();
  endtask

  task automatic test_reset();
    btn = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (t !== 1'b0 || pressed !== 1'b0 || glitch_cnt !== 8'd0) begin
        $display("FAIL reset_hold: t=%b pressed=%b glitch=%0d expected 0/0/0", t, pressed, glitch_cnt);
        n_fail++;
      end
    end
    rst = 1'b0;
    p_count = 0;
    pulse_cyc.delete();
    ticks(5);
    n_checks++;
    if (t !== 1'b0) begin
      $display("FAIL reset_early_t: t=%b after 5 edges expected 0", t);
      n_fail++;
    end
    tick();
    n_checks++;
    if (t !== 1'b1 || pressed !== 1'b1) begin
      $display("FAIL reset_repress: t=%b pressed=%b after 6 edges expected 1/1", t, pressed);
      n_fail++;
    end
    tick();
    n_checks++;
    if (t !== 1'b0 || p_count !== 1) begin
      $display("FAIL reset_pulse_width: t=%b pulses=%0d expected 0/1", t, p_count);
      n_fail++;
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    btn = 1'b1;
    ticks(5);
    n_checks++;
    if (pressed !== 1'b0 || t !== 1'b0) begin
      $display("FAIL press_early: pressed=%b t=%b expected 0/0", pressed, t);
      n_fail++;
    end
    tick();
    n_checks++;
    if (pressed !== 1'b1 || t !== 1'b1) begin
      $display("FAIL press_e5: pressed=%b t=%b expected 1/1", pressed, t);
      n_fail++;
    end
    ticks(24);
    btn = 1'b0;
    ticks(5);
    n_checks++;
    if (pressed !== 1'b1) begin
      $display("FAIL release_early: pressed=%b expected 1", pressed);
      n_fail++;
    end
    tick();
    n_checks++;
    if (pressed !== 1'b0) begin
      $display("FAIL release_e5: pressed=%b expected 0", pressed);
      n_fail++;
    end
    ticks(24);
    n_checks++;
    if (p_count !== EXP_CLEAN_PULSES || glitch_cnt !== 8'd0) begin
      $display("FAIL clean_summary: pulses=%0d glitch=%0d expected %0d/0", p_count, glitch_cnt, EXP_CLEAN_PULSES);
      n_fail++;
    end
  endtask

  task automatic test_press_bounce();
    int seen_pressed;
    do_reset();
    seen_pressed = 0;
    btn = 1'b1;
    ticks(2);
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pressed === 1'b1) seen_pressed++;
    end
    n_checks++;
    if (p_count !== 0 || seen_pressed !== 0 || glitch_cnt !== 8'd1) begin
      $display("FAIL press_bounce: pulses=%0d pressed_cycles=%0d glitch=%0d expected 0/0/1", p_count, seen_pressed, glitch_cnt);
      n_fail++;
    end
  endtask

  task automatic test_release_bounce();
    int low_cycles;
    do_reset();
    low_cycles = 0;
    btn = 1'b1;
    ticks(8);
    btn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (pressed !== 1'b1) low_cycles++;
    end
    btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pressed !== 1'b1) low_cycles++;
    end
    n_checks++;
    if (low_cycles !== 0 || p_count !== 1 || glitch_cnt !== 8'd1) begin
      $display("FAIL release_bounce: low_cycles=%0d pulses=%0d glitch=%0d expected 0/1/1", low_cycles, p_count, glitch_cnt);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      btn = 1'b1;
      ticks(2);
      btn = 1'b0;
      ticks(3);
      if (i == 254) begin
        n_checks++;
        if (glitch_cnt !== 8'd254) begin
          $display("FAIL sat_254: glitch=%0d expected 254", glitch_cnt);
          n_fail++;
        end
      end else if (i == 255) begin
        n_checks++;
        if (glitch_cnt !== 8'd255) begin
          $display("FAIL sat_255: glitch=%0d expected 255", glitch_cnt);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (glitch_cnt !== 8'd255 || p_count !== 0) begin
      $display("FAIL sat_hold: glitch=%0d pulses=%0d expected 255/0", glitch_cnt, p_count);
      n_fail++;
    end
  endtask

  task automatic test_auto_repeat();
    do_reset();
    btn = 1'b1;
    ticks(6);
    n_checks++;
    if (p_count !== 1) begin
      $display("FAIL repeat_first: pulses=%0d expected 1", p_count);
      n_fail++;
    end
    ticks(60);
    n_checks++;
    if (p_count !== EXP_REPEAT_PULSES) begin
      $display("FAIL repeat_count: pulses=%0d expected %0d", p_count, EXP_REPEAT_PULSES);
      n_fail++;
    end
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      n_checks++;
      if (pulse_cyc[i] - pulse_cyc[0] !== 16 * i) begin
        $display("FAIL repeat_spacing%0d: offset=%0d expected %0d", i, pulse_cyc[i] - pulse_cyc[0], 16 * i);
        n_fail++;
      end
    end
    n_checks++;
    if (q !== p_count[0]) begin
      $display("FAIL tff_q: q=%b expected %b", q, p_count[0]);
      n_fail++;
    end
    btn = 1'b0;
    ticks(8);
    n_checks++;
    if (pressed !== 1'b0) begin
      $display("FAIL repeat_release: pressed=%b expected 0", pressed);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_saturation();
    test_auto_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_btn_pulse.md
# tff_btn_pulse

Upstream stage for the T flip-flop: it turns a raw, bouncing, asynchronous push-button level into a clean single-cycle toggle-enable pulse `t`. Each debounced press produces exactly one `t` pulse, so the downstream flip-flop's `q` changes once per press. It also exports the debounced button level and a saturating count of rejected glitches for bring-up.

## Interface
- `DB_CYCLES`, 4: consecutive stable synchronized samples required to accept a press or a release; legal range 2..255.
- `REPEAT_CYCLES`, 16: auto-repeat period in clocks; used only when `TFF_BTN_AUTO_REPEAT_EN` is defined; legal range 2..65535.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn`  in  1  raw button level; asynchronous to `clk`; may bounce.
- `t`  out  1  registered toggle pulse, exactly one cycle wide; drives the T flip-flop's `t` input.
- `pressed`  out  1  registered debounced button level.
- `glitch_cnt`  out  8  saturating count of aborted debounce attempts.

## Operation
- Input synchronizer: two flops, `sync0 <= btn`, `sync1 <= sync0`. `btn_s = sync1`. The FSM uses only `btn_s`.
- FSM states and debounce counter `db_cnt` (8 bits):
  - IDLE (`pressed`=0): if `btn_s`=1, go to PRESS_WAIT with `db_cnt`=1.
  - PRESS_WAIT (`pressed`=0):
    - if `btn_s`=0, go to IDLE and increment `glitch_cnt`;
    - else if `db_cnt`==DB_CYCLES-1, go to PRESSED and set `t`=1 for one cycle;
    - else increment `db_cnt`.
  - PRESSED (`pressed`=1): if `btn_s`=0, go to RELEASE_WAIT with `db_cnt`=1.
  - RELEASE_WAIT (`pressed`=1):
    - if `btn_s`=1, go to PRESSED and increment `glitch_cnt`; no `t` pulse;
    - else if `db_cnt`==DB_CYCLES-1, go to IDLE;
    - else increment `db_cnt`.
- `pressed` is registered. It is 1 in PRESSED and RELEASE_WAIT, and changes in the same cycle the state changes.
- `t` defaults to 0 every cycle. It is set only on the PRESS_WAIT→PRESSED transition, and on auto-repeat events (see Configuration).
- `glitch_cnt` saturates at 255; a further increment holds it at 255. It is cleared only by `rst`.
- Reset (`rst`=1 at a rising edge), regardless of state:
  - `sync0`, `sync1`, `db_cnt` and the repeat counter go to 0; state goes to IDLE;
  - `t`=0, `pressed`=0, `glitch_cnt`=0.
- Reset mid-operation: any in-flight debounce or pulse is discarded. If `btn` is still held when `rst` falls, it is re-debounced from IDLE and produces a new `t` pulse.

## Timing
- Let E0 be the first rising edge at which `btn`=1 is sampled into `sync0`, with `btn` stable from then on.
  - `btn_s` is 1 after E1; PRESS_WAIT is entered at E2.
  - `t`=1 and `pressed`=1 after edge E(DB_CYCLES+1). With the default DB_CYCLES=4, that is after E5.
  - `t` returns to 0 after the next edge.
- Release is symmetric: with E0 the first edge sampling `btn`=0, `pressed` falls after edge E(DB_CYCLES+1).
- A high or low pulse on `btn` shorter than DB_CYCLES-1 synchronized cycles never changes `pressed` and never produces `t`.
- Minimum spacing between two non-repeat `t` pulses: 2·DB_CYCLES cycles.
- `rst` has priority over every other event in the same cycle.

## Configuration
- Macro `TFF_BTN_AUTO_REPEAT_EN`.
- When defined:
  - a 16-bit repeat counter clears on entry to PRESSED and increments each cycle the FSM stays in PRESSED;
  - when it reaches REPEAT_CYCLES-1, `t`=1 for one cycle and the counter clears;
  - result: while the button is held, pulses repeat every REPEAT_CYCLES cycles after the initial pulse;
  - leaving PRESSED (to RELEASE_WAIT) clears the counter, and a return to PRESSED restarts the period from 0.
- When not defined: no repeat counter; exactly one `t` pulse per accepted press.

## Test plan
All scenarios use the defaults DB_CYCLES=4, REPEAT_CYCLES=16.
- Reset with `btn`=1 held, `rst`=1 for 3 cycles then 0 → `t`=0, `pressed`=0, `glitch_cnt`=0 while `rst`=1; a single `t` pulse appears 6 edges after `rst` falls.
- Clean press: hold `btn`=1 for 30 cycles, then 0 for 30 cycles → exactly one 1-cycle `t` after E5; `pressed` rises with `t` and falls 6 edges after release; `glitch_cnt`=0.
- Press bounce: `btn`=1 for 2 cycles then 0 → no `t`, `pressed` stays 0, `glitch_cnt`=1.
- Release bounce: while pressed, `btn`=0 for 2 cycles then 1 again → `pressed` stays 1, no new `t`, `glitch_cnt` increments by 1.
- Saturation: apply 300 short glitches → `glitch_cnt`=255 and holds at 255.
- Auto-repeat: hold `btn` 60 cycles past the first `t`.
  - With `TFF_BTN_AUTO_REPEAT_EN` defined → extra pulses 16, 32 and 48 cycles after the first.
  - Without the macro → no extra pulses.
  - With `t` driving a T flip-flop, `q` toggles once per observed pulse.
